mgnt_port_sched: RTL and testbench

- Sits on the system side of the SPI register controller's management interface. Decodes each one-hot `sys_req_valid` request and forwards it to one of `NUM_PORTS` MAC statistics banks.
- Manages the per-port read/ack handshake, then serializes the returned `MGNT_REG_WIDTH`-bit word onto the byte-wide `sys_resp` stream, MSB first.
- Makes sure the controller always receives a complete response, even when a port is unmapped or never acknowledges.

---
 rtl/mgnt_port_sched_if.sv | 29 ++
 rtl/mgnt_port_sched.sv | 177 +++++++++++++++++
 tb/tb_mgnt_port_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mgnt_port_sched_if.sv
// Management-side bundle for mgnt_port_sched: controller request/response stream plus the per-port stat-bank handshake.
// master = controller/stat-bank side, slave = the scheduler.
interface mgnt_port_sched_if #(
  parameter int NUM_PORTS      = 4,
  parameter int MGNT_REG_WIDTH = 32
);
  logic [5:0]                          sys_req_valid;
  logic                                sys_req_wr;
  logic [7:0]                          sys_req_addr;
  logic                                sys_resp_valid;
  logic [7:0]                          sys_resp_data;
  logic [NUM_PORTS-1:0]                port_rd_req;
  logic [NUM_PORTS-1:0]                port_wr_req;
  logic [7:0]                          port_addr;
  logic [NUM_PORTS-1:0]                port_rd_ack;
  logic [NUM_PORTS*MGNT_REG_WIDTH-1:0] port_rd_data;
  logic                                busy;
  logic [2:0]                          err_pulse;

  modport master (
    output sys_req_valid, sys_req_wr, sys_req_addr, port_rd_ack, port_rd_data,
    input  sys_resp_valid, sys_resp_data, port_rd_req, port_wr_req, port_addr, busy, err_pulse
  );

  modport slave (
    input  sys_req_valid, sys_req_wr, sys_req_addr, port_rd_ack, port_rd_data,
    output sys_resp_valid, sys_resp_data, port_rd_req, port_wr_req, port_addr, busy, err_pulse
  );
endinterface

// File: rtl/mgnt_port_sched.sv
// mgnt_port_sched: routes one-hot mgmt requests to per-port stat banks and streams the read word back MSB byte first.
// Optional clear-on-read after an acked read: define MGNT_SCHED_RD_CLR_EN.
module mgnt_port_sched #(
  parameter int NUM_PORTS      = 4,
  parameter int MGNT_REG_WIDTH = 32,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic             clk,
  input  logic             rst,
  mgnt_port_sched_if.slave bus
);
  localparam int NB = MGNT_REG_WIDTH / 8;
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WPULSE = 2'd1, RDREQ = 2'd2, SEND = 2'd3} state_t;

  state_t                    r_state, w_state_nxt;
  logic [NUM_PORTS-1:0]      r_sel, w_sel_nxt;
  logic [MGNT_REG_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [BW-1:0]             r_bcnt, w_bcnt_nxt;
  logic [TW-1:0]             r_tcnt, w_tcnt_nxt;
  logic                      r_resp_vld, w_resp_vld_nxt;
  logic [7:0]                r_resp_dat, w_resp_dat_nxt;
  logic [NUM_PORTS-1:0]      r_rd_req, w_rd_req_nxt;
  logic [NUM_PORTS-1:0]      r_wr_req, w_wr_req_nxt;
  logic [7:0]                r_addr, w_addr_nxt;
  logic                      r_busy;
  logic [2:0]                r_err, w_err_nxt;

  logic [5:0]                w_req;
  logic                      w_multi;
  logic [NUM_PORTS-1:0]      w_map;
  logic                      w_ack;
  logic [MGNT_REG_WIDTH-1:0] w_rd_word;
  logic [MGNT_REG_WIDTH-1:0] w_load_word;
  logic                      w_load;

  assign w_req   = bus.sys_req_valid;
  assign w_multi = (w_req & (w_req - 6'd1)) != 6'd0;
  assign w_ack   = |(bus.port_rd_ack & r_sel);

  // Lowest set bit among the mapped ports; zero means the winner is unmapped.
  always_comb begin
    w_map = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (w_req[i]) w_map = NUM_PORTS'(1) << i;
  end

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (r_sel[i]) w_rd_word = bus.port_rd_data[i*MGNT_REG_WIDTH +: MGNT_REG_WIDTH];
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_shift_nxt    = r_shift;
    w_bcnt_nxt     = r_bcnt;
    w_tcnt_nxt     = r_tcnt;
    w_addr_nxt     = r_addr;
    w_resp_vld_nxt = 1'b0;
    w_resp_dat_nxt = 8'd0;
    w_rd_req_nxt   = '0;
    w_wr_req_nxt   = '0;
    w_err_nxt      = 3'd0;
    w_load         = 1'b0;
    w_load_word    = '0;
    case (r_state)
      IDLE: begin
        if (w_req != 6'd0) begin
          w_err_nxt[1] = w_multi;
          if (w_map == '0) begin
            // Unmapped write is silently ignored; unmapped read answers with zeros.
            if (!bus.sys_req_wr) begin
              w_addr_nxt = bus.sys_req_addr;
              w_load     = 1'b1;
            end
          end else begin
            w_addr_nxt = bus.sys_req_addr;
            w_sel_nxt  = w_map;
            w_tcnt_nxt = '0;
            if (bus.sys_req_wr) begin
              w_state_nxt  = WPULSE;
              w_wr_req_nxt = w_map;
            end else begin
              w_state_nxt  = RDREQ;
              w_rd_req_nxt = w_map;
            end
          end
        end
      end
      WPULSE: begin
        w_err_nxt[2] = w_req != 6'd0;
        w_state_nxt  = IDLE;
      end
      RDREQ: begin
        w_err_nxt[2] = w_req != 6'd0;
        if (w_ack) begin
          w_load      = 1'b1;
          w_load_word = w_rd_word;
`ifdef MGNT_SCHED_RD_CLR_EN
          w_wr_req_nxt = r_sel;
`endif
        end else if (r_tcnt == TO_LAST) begin
          w_load       = 1'b1;
          w_load_word  = '1;
          w_err_nxt[0] = 1'b1;
        end else begin
          w_tcnt_nxt   = r_tcnt + TW'(1);
          w_rd_req_nxt = r_sel;
        end
      end
      SEND: begin
        w_err_nxt[2] = w_req != 6'd0;
        if (r_bcnt == B_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_resp_vld_nxt = 1'b1;
          w_resp_dat_nxt = r_shift[MGNT_REG_WIDTH-1 -: 8];
          w_shift_nxt    = r_shift << 8;
          w_bcnt_nxt     = r_bcnt + BW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // First byte leaves with the load so bytes start the cycle after ack/accept.
    if (w_load) begin
      w_state_nxt    = SEND;
      w_resp_vld_nxt = 1'b1;
      w_resp_dat_nxt = w_load_word[MGNT_REG_WIDTH-1 -: 8];
      w_shift_nxt    = w_load_word << 8;
      w_bcnt_nxt     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_shift    <= '0;
      r_bcnt     <= '0;
      r_tcnt     <= '0;
      r_resp_vld <= 1'b0;
      r_resp_dat <= 8'd0;
      r_rd_req   <= '0;
      r_wr_req   <= '0;
      r_addr     <= 8'd0;
      r_busy     <= 1'b0;
      r_err      <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_shift    <= w_shift_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_resp_vld <= w_resp_vld_nxt;
      r_resp_dat <= w_resp_dat_nxt;
      r_rd_req   <= w_rd_req_nxt;
      r_wr_req   <= w_wr_req_nxt;
      r_addr     <= w_addr_nxt;
      r_busy     <= w_state_nxt != IDLE;
      r_err      <= w_err_nxt;
    end
  end

  assign bus.sys_resp_valid = r_resp_vld;
  assign bus.sys_resp_data  = r_resp_dat;
  assign bus.port_rd_req    = r_rd_req;
  assign bus.port_wr_req    = r_wr_req;
  assign bus.port_addr      = r_addr;
  assign bus.busy           = r_busy;
  assign bus.err_pulse      = r_err;
endmodule

// File: tb/tb_mgnt_port_sched.sv
// Bench for mgnt_port_sched: directed transaction table, busy-drop and reset sequences,
// then random traffic checked cycle by cycle against a transaction-schedule model.
`timescale 1ns/1ps
module tb_mgnt_port_sched;
  localparam int NP    = 4;
  localparam int W     = 32;
  localparam int NB    = W / 8;
  localparam int TO    = 255;
  localparam int WIN   = 262;
  localparam int MAXC  = 9000;
  localparam int NRAND = 8000;
`ifdef MGNT_SCHED_RD_CLR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mgnt_port_sched_if #(.NUM_PORTS(NP), .MGNT_REG_WIDTH(W)) bus ();

  mgnt_port_sched #(.NUM_PORTS(NP), .MGNT_REG_WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic          vld;
    logic [7:0]    dat;
    logic [NP-1:0] rd;
    logic [NP-1:0] wr;
    logic [7:0]    addr;
    logic          busy;
    logic [2:0]    err;
  } obs_t;

  typedef struct packed {
    logic [5:0]    vld;
    logic          wr;
    logic [7:0]    addr;
    int            port;
    int            ack_off;
    logic [31:0]   data;
    logic [NP-1:0] noise;
    int            e_nb;
    logic [31:0]   e_word;
    int            e_first;
    logic [2:0]    e_err;
    int            e_wrcnt;
    logic [NP-1:0] e_wrvec;
    int            e_wroff;
    int            e_rdcyc;
    logic [NP-1:0] e_rdvec;
    int            e_blast;
    logic [7:0]    e_addr;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl [9];
  obs_t exp_o [MAXC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.vld  = bus.sys_resp_valid;
    o.dat  = bus.sys_resp_data;
    o.rd   = bus.port_rd_req;
    o.wr   = bus.port_wr_req;
    o.addr = bus.port_addr;
    o.busy = bus.busy;
    o.err  = bus.err_pulse;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.sys_req_valid = 6'd0;
    bus.sys_req_wr    = 1'b0;
    bus.sys_req_addr  = 8'd0;
    bus.port_rd_ack   = '0;
    for (int i = 0; i < NP; i++) bus.port_rd_data[i*W +: W] = $urandom;
  endtask

  task automatic drive_ack(input vec_t v, input int off);
    bus.port_rd_ack = v.noise;
    for (int i = 0; i < NP; i++) bus.port_rd_data[i*W +: W] = $urandom;
    bus.port_rd_data[v.port*W +: W] = v.data;
    // Rows without a real ack get a late ack while the response is streaming.
    if (off == v.ack_off || (v.ack_off == 0 && off == TO + 1)) bus.port_rd_ack[v.port] = 1'b1;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    obs_t          o;
    int            nb = 0, first = 0, last = 0, wrcnt = 0, wroff = 0, rdcyc = 0, blast = 0, dat_idle = 0;
    logic [31:0]   word = '0;
    logic [2:0]    err = '0;
    logic [NP-1:0] wrvec = '0, rdvec = '0;
    logic [7:0]    addr1 = '0;
    bus.sys_req_valid = v.vld;
    bus.sys_req_wr    = v.wr;
    bus.sys_req_addr  = v.addr;
    drive_ack(v, 0);
    for (int off = 1; off <= WIN; off++) begin
      step();
      if (off == 1) begin
        bus.sys_req_valid = 6'd0;
        bus.sys_req_wr    = 1'b0;
        bus.sys_req_addr  = 8'd0;
      end
      drive_ack(v, off);
      o = observe();
      if (off == 1) addr1 = o.addr;
      if (o.vld) begin
        if (nb == 0) first = off;
        last = off;
        word = {word[23:0], o.dat};
        nb++;
      end else if (o.dat != 8'd0) begin
        dat_idle++;
      end
      err = err | o.err;
      if (o.wr != '0) begin
        wrcnt++;
        wrvec = wrvec | o.wr;
        wroff = off;
      end
      if (o.rd != '0) begin
        rdcyc++;
        rdvec = rdvec | o.rd;
      end
      if (o.busy) blast = off;
    end
    chk($sformatf("row%0d addr", idx), addr1, v.e_addr);
    chk($sformatf("row%0d nbytes", idx), nb, v.e_nb);
    chk($sformatf("row%0d word", idx), word, v.e_word);
    chk($sformatf("row%0d first_byte", idx), first, v.e_first);
    chk($sformatf("row%0d last_byte", idx), last, (v.e_nb > 0) ? v.e_first + v.e_nb - 1 : 0);
    chk($sformatf("row%0d err", idx), err, v.e_err);
    chk($sformatf("row%0d wr_cnt", idx), wrcnt, v.e_wrcnt);
    chk($sformatf("row%0d wr_vec", idx), wrvec, v.e_wrvec);
    chk($sformatf("row%0d wr_off", idx), wroff, v.e_wroff);
    chk($sformatf("row%0d rd_cycles", idx), rdcyc, v.e_rdcyc);
    chk($sformatf("row%0d rd_vec", idx), rdvec, v.e_rdvec);
    chk($sformatf("row%0d busy_last", idx), blast, v.e_blast);
    chk($sformatf("row%0d idle_data", idx), dat_idle, 0);
  endtask

  task automatic seq_busy_drop();
    obs_t        o;
    int          nb = 0, rdcyc = 0, blast = 0;
    logic [31:0] word = '0;
    logic [2:0]  err4 = '0;
    drive_idle();
    bus.sys_req_valid = 6'h01;
    bus.sys_req_addr  = 8'hAB;
    for (int off = 1; off <= 12; off++) begin
      step();
      drive_idle();
      if (off == 1) begin
        bus.port_rd_ack    = 4'b0001;
        bus.port_rd_data[0 +: W] = 32'h01020304;
      end
      if (off == 3) bus.sys_req_valid = 6'h02;
      o = observe();
      if (o.vld) begin
        nb++;
        word = {word[23:0], o.dat};
      end
      if (o.rd != '0) rdcyc++;
      if (o.busy) blast = off;
      if (off == 4) err4 = o.err;
    end
    chk("drop err_pulse", err4, 3'b100);
    chk("drop nbytes", nb, 4);
    chk("drop word", word, 32'h01020304);
    chk("drop rd_cycles", rdcyc, 1);
    chk("drop busy_last", blast, 5);
  endtask

  task automatic seq_reset_mid_send();
    obs_t        o;
    int          nb = 0, blast = 0;
    logic [31:0] word = '0;
    obs_t        o4 = '1;
    drive_idle();
    bus.sys_req_valid = 6'h02;
    bus.sys_req_addr  = 8'h5C;
    for (int off = 1; off <= 10; off++) begin
      step();
      drive_idle();
      if (off == 1) begin
        bus.port_rd_ack = 4'b0010;
        bus.port_rd_data[W +: W] = 32'hDEADBEEF;
      end
      rst = (off == 3) ? 1'b0 : 1'b1;
      o = observe();
      if (o.vld) begin
        nb++;
        word = {word[23:0], o.dat};
      end
      if (o.busy) blast = off;
      if (off == 4) o4 = o;
    end
    chk("rst outputs_cleared", o4, '0);
    chk("rst nbytes", nb, 2);
    chk("rst word", word, 32'h0000DEAD);
    chk("rst busy_last", blast, 3);
  endtask

  task automatic sched_send(input int s, input logic [W-1:0] word);
    for (int k = 0; k < NB; k++) begin
      exp_o[s+k].vld  = 1'b1;
      exp_o[s+k].dat  = word[(NB-1-k)*8 +: 8];
      exp_o[s+k].busy = 1'b1;
    end
  endtask

  task automatic run_random();
    obs_t          o;
    logic [5:0]    rv;
    logic          rw, req;
    logic [7:0]    ra;
    logic [NP-1:0] noise, pend_sel;
    logic [31:0]   pend_word;
    int            l, d, pick, nwait, pend_end, pend_ack;
    for (int c = 0; c < MAXC; c++) exp_o[c] = '0;
    pend_end  = -1;
    pend_ack  = -1;
    pend_sel  = '0;
    pend_word = '0;
    rst = 1'b0;
    drive_idle();
    step();
    step();
    rst = 1'b1;
    for (int c = 0; c < NRAND; c++) begin
      o = observe();
      chk($sformatf("rand cyc%0d", c), o, exp_o[c]);
      drive_idle();
      req = 1'b0;
      if (c + TO + NB + 4 < NRAND) begin
        if (!exp_o[c].busy) req = ($urandom_range(0, 2) == 0);
        else                req = ($urandom_range(0, 19) == 0);
      end
      if (req) begin
        rv = ($urandom_range(0, 9) < 7) ? (6'b1 << $urandom_range(0, 5)) : 6'($urandom_range(1, 63));
        rw = ($urandom_range(0, 3) == 0);
        ra = 8'($urandom);
        bus.sys_req_valid = rv;
        bus.sys_req_wr    = rw;
        bus.sys_req_addr  = ra;
        if (exp_o[c].busy) begin
          exp_o[c+1].err[2] = 1'b1;
        end else begin
          l = 0;
          for (int b = 5; b >= 0; b--) if (rv[b]) l = b;
          if ($countones(rv) > 1) exp_o[c+1].err[1] = 1'b1;
          if (!(l >= NP && rw)) begin
            for (int k = c + 1; k < MAXC; k++) exp_o[k].addr = ra;
            if (l >= NP) begin
              sched_send(c + 1, '0);
            end else if (rw) begin
              exp_o[c+1].wr[l] = 1'b1;
              exp_o[c+1].busy  = 1'b1;
            end else begin
              pick  = $urandom_range(0, 9);
              d     = (pick < 8) ? $urandom_range(1, 8) : (pick == 8) ? $urandom_range(9, TO) : 0;
              nwait = (d == 0) ? TO : d;
              for (int k = 1; k <= nwait; k++) begin
                exp_o[c+k].rd[l] = 1'b1;
                exp_o[c+k].busy  = 1'b1;
              end
              pend_sel = NP'(1) << l;
              pend_end = c + nwait;
              if (d == 0) begin
                pend_ack = -1;
                exp_o[c+TO+1].err[0] = 1'b1;
                sched_send(c + TO + 1, '1);
              end else begin
                pend_ack  = c + d;
                pend_word = $urandom;
                sched_send(c + d + 1, pend_word);
                if (CLR) exp_o[c+d+1].wr[l] = 1'b1;
              end
            end
          end
        end
      end
      noise = 4'($urandom) & 4'($urandom);
      if (c <= pend_end) noise = noise & ~pend_sel;
      if (c == pend_ack) begin
        noise = noise | pend_sel;
        for (int i = 0; i < NP; i++) if (pend_sel[i]) bus.port_rd_data[i*W +: W] = pend_word;
      end
      bus.port_rd_ack = noise;
      step();
    end
  endtask

  initial begin
    //                vld    wr    addr   port ack_off data           noise    nb word           first   err     wrcnt        wrvec                    wroff                rdcyc rdvec    blast addr
    tbl[0] = '{6'h04, 1'b0, 8'h10, 2, 4,    32'hA1B2C3D4, 4'b1001, 4, 32'hA1B2C3D4, 5,      3'b000, CLR ? 1 : 0, CLR ? 4'b0100 : 4'b0000, CLR ? 5 : 0,         4,    4'b0100, 8,    8'h10};
    tbl[1] = '{6'h01, 1'b1, 8'h22, 0, 0,    32'h0,        4'b0000, 0, 32'h0,        0,      3'b000, 1,           4'b0001,                 1,                   0,    4'b0000, 1,    8'h22};
    tbl[2] = '{6'h08, 1'b0, 8'h33, 3, 0,    32'h12121212, 4'b0111, 4, 32'hFFFFFFFF, TO + 1, 3'b001, 0,           4'b0000,                 0,                   TO,   4'b1000, TO+4, 8'h33};
    tbl[3] = '{6'h20, 1'b0, 8'h44, 0, 0,    32'h0,        4'b1111, 4, 32'h0,        1,      3'b000, 0,           4'b0000,                 0,                   0,    4'b0000, 4,    8'h44};
    tbl[4] = '{6'h06, 1'b0, 8'h55, 1, 2,    32'h12345678, 4'b0100, 4, 32'h12345678, 3,      3'b010, CLR ? 1 : 0, CLR ? 4'b0010 : 4'b0000, CLR ? 3 : 0,         2,    4'b0010, 6,    8'h55};
    tbl[5] = '{6'h20, 1'b1, 8'hEE, 0, 0,    32'h0,        4'b0000, 0, 32'h0,        0,      3'b000, 0,           4'b0000,                 0,                   0,    4'b0000, 0,    8'h55};
    tbl[6] = '{6'h04, 1'b0, 8'h66, 2, TO,   32'hCAFEF00D, 4'b1011, 4, 32'hCAFEF00D, TO + 1, 3'b000, CLR ? 1 : 0, CLR ? 4'b0100 : 4'b0000, CLR ? TO + 1 : 0,    TO,   4'b0100, TO+4, 8'h66};
    tbl[7] = '{6'h0A, 1'b1, 8'h77, 1, 0,    32'h0,        4'b0000, 0, 32'h0,        0,      3'b010, 1,           4'b0010,                 1,                   0,    4'b0000, 1,    8'h77};
    tbl[8] = '{6'h30, 1'b0, 8'h88, 0, 0,    32'h0,        4'b0000, 4, 32'h0,        1,      3'b010, 0,           4'b0000,                 0,                   0,    4'b0000, 4,    8'h88};

    rst = 1'b0;
    drive_idle();
    step();
    step();
    step();
    chk("reset outputs", observe(), '0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_row(tbl[i], i);
    seq_busy_drop();
    seq_reset_mid_send();
    run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
